// File: rtl/spi_master_tx.sv
// SPI master transmitter: serialises one word per frame with cs setup/hold and
// inter-frame gap, capturing the slave's miso reply into rx_data.
module spi_master_tx #(
    parameter int DATA_W    = 8,
    parameter int CS_SETUP  = 1,
    parameter int CS_HOLD   = 1,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              sclk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int M1    = (DATA_W > CS_SETUP) ? DATA_W : CS_SETUP;
    localparam int M2    = (M1 > CS_HOLD) ? M1 : CS_HOLD;
    localparam int MAXC  = (M2 > GAP) ? M2 : GAP;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    if (CS_SETUP < 1) begin : g_bad_setup
        $error("spi_master_tx: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_bad_hold
        $error("spi_master_tx: CS_HOLD must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("spi_master_tx: GAP must be >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              nxt_bit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        nxt_bit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                cs_d       = 1'b1;
                mosi_d     = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    state_d    = ST_SETUP;
                    cnt_d      = '0;
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cs_d       = 1'b0;
                    mosi_d     = (MSB_FIRST != 0) ? tx_data[DATA_W-1]
                                                  : tx_data[0];
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // miso is captured at the edge that closes each shift cycle
                if (MSB_FIRST != 0) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    nxt_bit    = tx_shift_q[DATA_W-2];
                end else begin
                    rx_shift_d = {miso, rx_shift_q[DATA_W-1:1]};
                    tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                    nxt_bit    = tx_shift_q[1];
                end
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    mosi_d = nxt_bit;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d    = ST_GAP;
                    cnt_d      = '0;
                    cs_d       = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                tx_ready_d = 1'b0;
                busy_d     = 1'b0;
                cs_d       = 1'b1;
                mosi_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: MSB-first instance with loopback or
// scripted miso, plus an LSB-first instance in loopback.
module tb_spi_master_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       loop_en;
    logic       miso_pat;

    logic [7:0] l_tx_data;
    logic       l_tx_valid;
    logic       l_tx_ready;
    logic [7:0] l_rx_data;
    logic       l_rx_valid;
    logic       l_busy;
    logic       l_cs;
    logic       l_mosi;

    int n_checks = 0;
    int n_err    = 0;

    logic cs_a   [0:31];
    logic mosi_a [0:31];
    logic rv_a   [0:31];
    logic busy_a [0:31];
    logic rdy_a  [0:31];
    logic [7:0] rd_a [0:31];

    assign miso = loop_en ? mosi : miso_pat;

    spi_master_tx #(
        .DATA_W(8), .CS_SETUP(1), .CS_HOLD(1), .GAP(2), .MSB_FIRST(1)
    ) u_msb (
        .sclk(clk), .i_reset_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .cs(cs), .mosi(mosi), .miso(miso)
    );

    spi_master_tx #(
        .DATA_W(8), .CS_SETUP(1), .CS_HOLD(1), .GAP(2), .MSB_FIRST(0)
    ) u_lsb (
        .sclk(clk), .i_reset_n(rst_n),
        .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(l_tx_ready),
        .rx_data(l_rx_data), .rx_valid(l_rx_valid), .busy(l_busy),
        .cs(l_cs), .mosi(l_mosi), .miso(l_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic o, input logic e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] o,
                         input logic [7:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_i(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // Time-ordered mosi bits from cycle s: first bit lands in bit 7.
    function automatic logic [7:0] seq8(input int s);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[6:0], mosi_a[s+i]};
        return w;
    endfunction

    function automatic int cs_low(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (cs_a[i] === 1'b0) n++;
        return n;
    endfunction

    function automatic int rv_cnt(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (rv_a[i] === 1'b1) n++;
        return n;
    endfunction

    // Cycle 0 = first SETUP cycle; shift cycle k = cycle k+1.
    task automatic frame(input logic [7:0] d, input logic [7:0] reply,
                         input logic loop, input int pulse_c, input int n);
        loop_en  = loop;
        miso_pat = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < n; c++) begin
            cs_a[c]   = cs;
            mosi_a[c] = mosi;
            rv_a[c]   = rx_valid;
            rd_a[c]   = rx_data;
            busy_a[c] = busy;
            rdy_a[c]  = tx_ready;
            miso_pat  = (c >= 1 && c <= 8) ? reply[8-c] : 1'b0;
            if (c == pulse_c) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic lframe(input logic [7:0] d, input logic [7:0] exp_seq);
        int rvn;
        rvn = 0;
        l_tx_data  = d;
        l_tx_valid = 1'b1;
        tick();
        l_tx_valid = 1'b0;
        for (int c = 0; c < 13; c++) begin
            mosi_a[c] = l_mosi;
            if (l_rx_valid === 1'b1) begin
                rvn++;
                chk_w("lsb_rx_data", l_rx_data, d);
            end
            tick();
        end
        chk_w("lsb_mosi_seq", seq8(1), exp_seq);
        chk_i("lsb_rv_count", rvn, 1);
    endtask

    initial begin
        logic all_busy;
        int   hi;
        rst_n      = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        loop_en    = 1'b1;
        miso_pat   = 1'b0;
        l_tx_data  = '0;
        l_tx_valid = 1'b0;

        tick();
        tick();
        chk_b("rst_cs", cs, 1'b1);
        chk_b("rst_mosi", mosi, 1'b0);
        chk_b("rst_ready", tx_ready, 1'b0);
        chk_b("rst_rv", rx_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_w("rst_rxd", rx_data, 8'h00);
        rst_n = 1'b1;
        tick();
        chk_b("ready_after_rst", tx_ready, 1'b1);

        // Loopback 0xA5
        frame(8'hA5, 8'h00, 1'b1, -1, 13);
        chk_i("t1_cs_low", cs_low(0, 12), 10);
        chk_b("t1_setup_mosi", mosi_a[0], 1'b1);
        chk_w("t1_mosi_seq", seq8(1), 8'hA5);
        chk_b("t1_hold_cs", cs_a[9], 1'b0);
        chk_b("t1_hold_mosi", mosi_a[9], 1'b0);
        chk_i("t1_rv_count", rv_cnt(0, 12), 1);
        chk_b("t1_rv_pos", rv_a[10], 1'b1);
        chk_w("t1_rx_data", rd_a[10], 8'hA5);
        chk_b("t1_busy_setup", busy_a[0], 1'b1);
        chk_b("t1_ready_setup", rdy_a[0], 1'b0);
        chk_b("t1_ready_idle", rdy_a[12], 1'b1);
        chk_b("t1_busy_idle", busy_a[12], 1'b0);

        // tx_valid held: data changes while busy have no effect
        loop_en  = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hC3;
        for (int c = 0; c < 26; c++) begin
            cs_a[c]   = cs;
            mosi_a[c] = mosi;
            rv_a[c]   = rx_valid;
            rd_a[c]   = rx_data;
            if (c < 25) tick();
        end
        tx_valid = 1'b0;
        tick();
        chk_w("t2_seq_a", seq8(1), 8'h3C);
        chk_w("t2_seq_b", seq8(14), 8'hC3);
        chk_i("t2_cs_low_a", cs_low(0, 9), 10);
        chk_i("t2_cs_low_b", cs_low(13, 22), 10);
        // cs high spans the GAP cycles plus the accepting IDLE cycle
        hi = 13 - cs_low(10, 12) - 10;
        chk_i("t2_cs_high", hi, 3);
        chk_i("t2_rv_count", rv_cnt(0, 25), 2);
        chk_w("t2_rxd_a", rd_a[10], 8'h3C);
        chk_w("t2_rxd_b", rd_a[23], 8'hC3);
        chk_b("t2_no_third", cs, 1'b1);

        // Scripted slave: slave receives 0x5A, replies 0x96
        frame(8'h5A, 8'h96, 1'b0, -1, 13);
        chk_w("t3_slave_dout", seq8(1), 8'h5A);
        chk_w("t3_rx_data", rd_a[10], 8'h96);
        chk_i("t3_rv_count", rv_cnt(0, 12), 1);
        loop_en = 1'b1;

        // Reset in shift cycle 3
        frame(8'hA5, 8'h00, 1'b1, -1, 4);
        chk_b("t4_pre_cs", cs, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_b("t4_cs", cs, 1'b1);
        chk_b("t4_mosi", mosi, 1'b0);
        chk_w("t4_rxd", rx_data, 8'h00);
        chk_b("t4_rv", rx_valid, 1'b0);
        chk_b("t4_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_b("t4_ready", tx_ready, 1'b1);
        for (int c = 0; c < 14; c++) begin
            rv_a[c] = rx_valid;
            cs_a[c] = cs;
            tick();
        end
        chk_i("t4_no_rv", rv_cnt(0, 13), 0);
        chk_i("t4_cs_idle", cs_low(0, 13), 0);

        // tx_valid pulse with 0xFF mid-frame is ignored
        frame(8'h81, 8'h00, 1'b1, 4, 13);
        chk_w("t5_mosi_seq", seq8(1), 8'h81);
        all_busy = 1'b1;
        for (int c = 0; c < 12; c++) all_busy = all_busy & busy_a[c];
        chk_b("t5_busy_frame", all_busy, 1'b1);
        chk_b("t5_busy_idle", busy_a[12], 1'b0);
        chk_w("t5_rx_data", rd_a[10], 8'h81);
        tick();
        chk_b("t5_no_frame", cs, 1'b1);

        // LSB-first instance in loopback
        chk_b("t6_ready", l_tx_ready, 1'b1);
        lframe(8'h01, 8'h80);
        lframe(8'h35, 8'hAC);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
